fpu_sqrt_iter: RTL and testbench

Parametrised, iterative IEEE-754-style floating-point square-root unit for the FPU arithmetic datapath. It generalises the fixed-width sqrt sequencer to any exponent/mantissa width and produces a correctly rounded result. It uses a restoring digit-by-digit algorithm, one root bit per cycle, and needs no divider. The unit is issued by the FPU arithmetic FSM for `op_sqrt` through a start/ready and valid/ack handshake.

---
 rtl/fpu_sqrt_iter_pkg.sv | 21 ++
 rtl/fpu_sqrt_iter.sv | 192 +++++++++++++++++++
 tb/tb_fpu_sqrt_iter.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_sqrt_iter_pkg.sv
// Shared FPU definitions for the iterative square-root unit.
package fpu_sqrt_iter_pkg;

    typedef enum logic [3:0] {
        sq_idle_st   = 4'd0,
        sq_unpack_st = 4'd1,
        sq_iter_st   = 4'd2,
        sq_round_st  = 4'd3,
        sq_valid_st  = 4'd4
    } e_sqrt_iter_st;

    localparam int unsigned QNAN_MAX_W = 128;

    // Canonical quiet NaN {0, all-ones exponent, 1 followed by zeros}, right-aligned.
    function automatic logic [QNAN_MAX_W-1:0] qnan(input int unsigned exp_w, input int unsigned man_w);
        logic [QNAN_MAX_W-1:0] one;
        one = QNAN_MAX_W'(1);
        return (((one << exp_w) - one) << man_w) | (one << (man_w - 1));
    endfunction

endpackage

// File: rtl/fpu_sqrt_iter.sv
// Iterative floating-point square root: restoring digit-by-digit, one root bit per cycle,
// round-to-nearest, with denormal flush-to-zero and IEEE special-case handling.
module fpu_sqrt_iter
    import fpu_sqrt_iter_pkg::*;
#(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   arst_n,
    input  logic                   start,
    input  logic [EXP_W+MAN_W:0]   operand,
    output logic                   ready,
    output logic [EXP_W+MAN_W:0]   result,
    output logic                   result_valid,
    input  logic                   result_ack,
    output logic                   invalid
);

    localparam int unsigned W        = 1 + EXP_W + MAN_W;
    localparam int unsigned ROOT_W   = MAN_W + 2;
    localparam int unsigned REM_W    = MAN_W + 4;
    localparam int unsigned RAD_W    = 2 * MAN_W + 4;
    localparam int unsigned CNT_W    = $clog2(MAN_W + 3);
    localparam int unsigned BIAS     = 2 ** (EXP_W - 1) - 1;
    localparam int unsigned LAST_CNT = MAN_W + 1;
    localparam logic [W-1:0] QNAN    = W'(qnan(EXP_W, MAN_W));

    // One restoring step; returns {rem, root}.
    function automatic logic [REM_W+ROOT_W-1:0] sqrt_step(input logic [REM_W-1:0]  rem,
                                                          input logic [ROOT_W-1:0] root,
                                                          input logic [1:0]        bits);
        logic [REM_W:0] shifted;
        logic [REM_W:0] trial;
        logic [REM_W:0] diff;
        shifted = (REM_W+1)'({rem, bits});
        trial   = (REM_W+1)'({root, 2'b01});
        diff    = shifted - trial;
        if (diff[REM_W])
            return {shifted[REM_W-1:0], ROOT_W'({root, 1'b0})};
        return {diff[REM_W-1:0], ROOT_W'({root, 1'b1})};
    endfunction

    e_sqrt_iter_st state_q, state_d;

    logic [W-1:0]      op_q, op_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ROOT_W-1:0] root_q, root_d;
    logic [REM_W-1:0]  rem_q, rem_d;
    logic [RAD_W-1:0]  rad_q, rad_d;
    logic [EXP_W-1:0]  exp_q, exp_d;
    logic [W-1:0]      result_d;
    logic              invalid_d;

    logic                    op_sign, exp_ones, exp_zero, man_zero, is_special, e_odd;
    logic [EXP_W-1:0]        op_exp;
    logic [MAN_W-1:0]        op_man;
    logic [W-1:0]            spec_result;
    logic                    spec_invalid;
    logic [RAD_W-1:0]        norm_rad;
    logic [EXP_W-1:0]        norm_exp;
    logic [REM_W+ROOT_W-1:0] step;
    logic [MAN_W+1:0]        rnd_sum;
    logic                    rnd_carry;
    logic [MAN_W-1:0]        rnd_man;
    logic [EXP_W-1:0]        rnd_exp;

    assign op_sign    = op_q[W-1];
    assign op_exp     = op_q[W-2:MAN_W];
    assign op_man     = op_q[MAN_W-1:0];
    assign exp_ones   = &op_exp;
    assign exp_zero   = ~|op_exp;
    assign man_zero   = ~|op_man;
    assign is_special = exp_ones | exp_zero | op_sign;

    // Parity of the unbiased exponent; floor((exp - bias)/2) + bias == floor((exp + bias)/2).
    assign e_odd    = op_exp[0] ^ 1'(BIAS);
    assign norm_exp = EXP_W'(({1'b0, op_exp} + (EXP_W+1)'(BIAS)) >> 1);
    assign norm_rad = e_odd ? {1'b1, op_man, {(MAN_W+3){1'b0}}}
                            : {1'b0, 1'b1, op_man, {(MAN_W+2){1'b0}}};

    always_comb begin
        spec_result  = op_q;
        spec_invalid = 1'b0;
        if (exp_ones && !man_zero) begin
            spec_result = QNAN;
        end else if (exp_zero) begin
            spec_result = {op_sign, (W-1)'(0)};
        end else if (op_sign) begin
            spec_result  = QNAN;
            spec_invalid = 1'b1;
        end
    end

    assign step = sqrt_step(rem_q, root_q, rad_q[RAD_W-1 -: 2]);

    // Guard bit decides the round; a carry into the hidden position bumps the exponent.
    assign rnd_sum   = {1'b0, root_q[ROOT_W-1:1]} + (MAN_W+2)'(root_q[0]);
    assign rnd_carry = (rnd_sum[MAN_W+1:MAN_W] == 2'b10);
    assign rnd_man   = rnd_carry ? '0 : rnd_sum[MAN_W-1:0];
    assign rnd_exp   = rnd_carry ? exp_q + EXP_W'(1) : exp_q;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) state_q <= sq_idle_st;
        else         state_q <= state_d;
    end

    // Unpack spends one cycle latching the radicand before it branches.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            sq_idle_st:   if (start) state_d = sq_unpack_st;
            sq_unpack_st: if (cnt_q != '0) state_d = is_special ? sq_valid_st : sq_iter_st;
            sq_iter_st:   if (cnt_q == CNT_W'(LAST_CNT)) state_d = sq_round_st;
            sq_round_st:  state_d = sq_valid_st;
            sq_valid_st:  if (result_ack) state_d = sq_idle_st;
            default:      state_d = sq_idle_st;
        endcase
    end

    // The first root bit is produced on the edge leaving unpack; cnt counts bits produced.
    always_comb begin
        op_d      = op_q;
        cnt_d     = cnt_q;
        root_d    = root_q;
        rem_d     = rem_q;
        rad_d     = rad_q;
        exp_d     = exp_q;
        result_d  = result;
        invalid_d = invalid;
        unique case (state_q)
            sq_idle_st: begin
                if (start) begin
                    op_d  = operand;
                    cnt_d = '0;
                end
            end
            sq_unpack_st: begin
                if (cnt_q == '0) begin
                    rad_d  = norm_rad;
                    exp_d  = norm_exp;
                    rem_d  = '0;
                    root_d = '0;
                    cnt_d  = CNT_W'(1);
                end else if (is_special) begin
                    result_d  = spec_result;
                    invalid_d = spec_invalid;
                end else begin
                    {rem_d, root_d} = step;
                    rad_d           = {rad_q[RAD_W-3:0], 2'b00};
                end
            end
            sq_iter_st: begin
                {rem_d, root_d} = step;
                rad_d           = {rad_q[RAD_W-3:0], 2'b00};
                cnt_d           = cnt_q + CNT_W'(1);
            end
            sq_round_st: begin
                result_d  = {1'b0, rnd_exp, rnd_man};
                invalid_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            op_q         <= '0;
            cnt_q        <= '0;
            root_q       <= '0;
            rem_q        <= '0;
            rad_q        <= '0;
            exp_q        <= '0;
            result       <= '0;
            invalid      <= 1'b0;
            ready        <= 1'b1;
            result_valid <= 1'b0;
        end else begin
            op_q         <= op_d;
            cnt_q        <= cnt_d;
            root_q       <= root_d;
            rem_q        <= rem_d;
            rad_q        <= rad_d;
            exp_q        <= exp_d;
            result       <= result_d;
            invalid      <= invalid_d;
            ready        <= (state_d == sq_idle_st);
            result_valid <= (state_d == sq_valid_st);
        end
    end

endmodule

// File: tb/tb_fpu_sqrt_iter.sv
// Directed bench for fpu_sqrt_iter: single and half precision instances, specials, handshake, reset.
module tb_fpu_sqrt_iter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        arst_n = 1'b1;
    logic        start_a = 1'b0, ack_a = 1'b0, ready_a, valid_a, inv_a;
    logic [31:0] op_a = '0, res_a;
    logic        start_b = 1'b0, ack_b = 1'b0, ready_b, valid_b, inv_b;
    logic [15:0] op_b = '0, res_b;

    int n_pass  = 0;
    int n_total = 0;

    fpu_sqrt_iter u_dut_a (
        .clk(clk), .arst_n(arst_n), .start(start_a), .operand(op_a), .ready(ready_a),
        .result(res_a), .result_valid(valid_a), .result_ack(ack_a), .invalid(inv_a)
    );

    fpu_sqrt_iter #(.EXP_W(5), .MAN_W(10)) u_dut_b (
        .clk(clk), .arst_n(arst_n), .start(start_b), .operand(op_b), .ready(ready_b),
        .result(res_b), .result_valid(valid_b), .result_ack(ack_b), .invalid(inv_b)
    );

    localparam logic [31:0] NORM_OP  [3] = '{32'h40800000, 32'h40000000, 32'h3F800000};
    localparam logic [31:0] NORM_EXP [3] = '{32'h40000000, 32'h3FB504F3, 32'h3F800000};
    localparam logic [31:0] SPEC_OP  [5] = '{32'hBF800000, 32'h7F800000, 32'h80000000,
                                             32'h00000001, 32'h7FA00000};
    localparam logic [31:0] SPEC_EXP [5] = '{32'h7FC00000, 32'h7F800000, 32'h80000000,
                                             32'h00000000, 32'h7FC00000};
    localparam logic        SPEC_INV [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [15:0] HALF_OP  [2] = '{16'h4000, 16'h4400};
    localparam logic [15:0] HALF_EXP [2] = '{16'h3DA8, 16'h4000};

    // Bounded wait for result_valid; cyc counts edges after the accept edge.
    task automatic wait_valid(input bit sel, output int cyc);
        cyc = 0;
        while (cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if ((sel ? valid_b : valid_a) === 1'b1) break;
        end
    endtask

    task automatic run_op(input bit sel, input logic [31:0] op, output logic [31:0] res,
                          output logic inv, output int cyc);
        @(negedge clk);
        if (sel) begin op_b = op[15:0]; start_b = 1'b1; end
        else     begin op_a = op;       start_a = 1'b1; end
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
        wait_valid(sel, cyc);
        res = sel ? {16'h0, res_b} : res_a;
        inv = sel ? inv_b : inv_a;
    endtask

    task automatic do_ack(input bit sel);
        @(negedge clk);
        if (sel) ack_b = 1'b1; else ack_a = 1'b1;
        @(posedge clk);
        #1;
        ack_a = 1'b0;
        ack_b = 1'b0;
    endtask

    task automatic test_reset();
        #1 arst_n = 1'b0;
        #2;
        n_total++; if (ready_a !== 1'b1) $display("FAIL reset_ready_a: got %b want 1", ready_a); else n_pass++;
        n_total++; if (valid_a !== 1'b0) $display("FAIL reset_valid_a: got %b want 0", valid_a); else n_pass++;
        n_total++; if (res_a !== 32'h0) $display("FAIL reset_result_a: got %h want 0", res_a); else n_pass++;
        n_total++; if (inv_a !== 1'b0) $display("FAIL reset_invalid_a: got %b want 0", inv_a); else n_pass++;
        n_total++; if (ready_b !== 1'b1 || valid_b !== 1'b0 || res_b !== 16'h0)
            $display("FAIL reset_b: got ready %b valid %b result %h want 1 0 0000", ready_b, valid_b, res_b);
        else n_pass++;
        @(negedge clk) arst_n = 1'b1;
    endtask

    task automatic test_normal();
        logic [31:0] res;
        logic        inv;
        int          cyc;
        for (int i = 0; i < 3; i++) begin
            run_op(1'b0, NORM_OP[i], res, inv, cyc);
            n_total++; if (res !== NORM_EXP[i]) $display("FAIL normal_result[%0d]: got %h want %h", i, res, NORM_EXP[i]); else n_pass++;
            n_total++; if (inv !== 1'b0) $display("FAIL normal_invalid[%0d]: got %b want 0", i, inv); else n_pass++;
            n_total++; if (cyc != 27) $display("FAIL normal_latency[%0d]: got %0d want 27", i, cyc); else n_pass++;
            do_ack(1'b0);
        end
        n_total++; if (ready_a !== 1'b1 || valid_a !== 1'b0)
            $display("FAIL normal_after_ack: got ready %b valid %b want 1 0", ready_a, valid_a);
        else n_pass++;
    endtask

    task automatic test_specials();
        logic [31:0] res;
        logic        inv;
        int          cyc;
        for (int i = 0; i < 5; i++) begin
            run_op(1'b0, SPEC_OP[i], res, inv, cyc);
            n_total++; if (res !== SPEC_EXP[i]) $display("FAIL special_result[%0d]: got %h want %h", i, res, SPEC_EXP[i]); else n_pass++;
            n_total++; if (inv !== SPEC_INV[i]) $display("FAIL special_invalid[%0d]: got %b want %b", i, inv, SPEC_INV[i]); else n_pass++;
            n_total++; if (cyc != 2) $display("FAIL special_latency[%0d]: got %0d want 2", i, cyc); else n_pass++;
            do_ack(1'b0);
        end
    endtask

    task automatic test_half();
        logic [31:0] res;
        logic        inv;
        int          cyc;
        for (int i = 0; i < 2; i++) begin
            run_op(1'b1, {16'h0, HALF_OP[i]}, res, inv, cyc);
            n_total++; if (res[15:0] !== HALF_EXP[i]) $display("FAIL half_result[%0d]: got %h want %h", i, res[15:0], HALF_EXP[i]); else n_pass++;
            n_total++; if (inv !== 1'b0) $display("FAIL half_invalid[%0d]: got %b want 0", i, inv); else n_pass++;
            n_total++; if (cyc != 14) $display("FAIL half_latency[%0d]: got %0d want 14", i, cyc); else n_pass++;
            do_ack(1'b1);
        end
    endtask

    task automatic test_hold();
        logic [31:0] res;
        logic        inv;
        int          cyc;
        run_op(1'b0, 32'h40800000, res, inv, cyc);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            n_total++; if (valid_a !== 1'b1 || res_a !== 32'h40000000)
                $display("FAIL hold[%0d]: got valid %b result %h want 1 40000000", i, valid_a, res_a);
            else n_pass++;
        end
        do_ack(1'b0);
    endtask

    task automatic test_busy_start();
        int cyc;
        @(negedge clk);
        op_a = 32'h3F800000;
        start_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        n_total++; if (res_a !== 32'h40000000 || ready_a !== 1'b0)
            $display("FAIL busy_mid: got result %h ready %b want 40000000 0", res_a, ready_a);
        else n_pass++;
        op_a = 32'h40000000;
        start_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0;
        wait_valid(1'b0, cyc);
        n_total++; if (res_a !== 32'h3F800000) $display("FAIL busy_result: got %h want 3f800000", res_a); else n_pass++;
        n_total++; if (cyc + 6 != 27) $display("FAIL busy_latency: got %0d want 27", cyc + 6); else n_pass++;
        do_ack(1'b0);
        repeat (3) @(posedge clk);
        #1;
        n_total++; if (ready_a !== 1'b1 || valid_a !== 1'b0)
            $display("FAIL busy_not_queued: got ready %b valid %b want 1 0", ready_a, valid_a);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] res;
        logic        inv;
        int          cyc;
        run_op(1'b0, 32'h40800000, res, inv, cyc);
        @(negedge clk);
        ack_a   = 1'b1;
        start_a = 1'b1;
        op_a    = 32'h40000000;
        @(posedge clk);
        #1 ack_a = 1'b0;
        n_total++; if (ready_a !== 1'b1 || valid_a !== 1'b0)
            $display("FAIL b2b_ack_edge: got ready %b valid %b want 1 0", ready_a, valid_a);
        else n_pass++;
        @(posedge clk);
        #1 start_a = 1'b0;
        n_total++; if (ready_a !== 1'b0) $display("FAIL b2b_accept: got ready %b want 0", ready_a); else n_pass++;
        wait_valid(1'b0, cyc);
        n_total++; if (res_a !== 32'h3FB504F3) $display("FAIL b2b_result: got %h want 3fb504f3", res_a); else n_pass++;
        n_total++; if (cyc != 27) $display("FAIL b2b_latency: got %0d want 27", cyc); else n_pass++;
        do_ack(1'b0);
    endtask

    task automatic test_async_reset();
        logic [31:0] res;
        logic        inv;
        int          cyc;
        @(negedge clk);
        op_a = 32'h40800000;
        start_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0;
        repeat (6) @(posedge clk);
        #2 arst_n = 1'b0;
        #1;
        n_total++; if (ready_a !== 1'b1 || valid_a !== 1'b0 || res_a !== 32'h0 || inv_a !== 1'b0)
            $display("FAIL areset_outputs: got ready %b valid %b result %h invalid %b want 1 0 00000000 0",
                     ready_a, valid_a, res_a, inv_a);
        else n_pass++;
        n_total++; if (res_b !== 16'h0) $display("FAIL areset_result_b: got %h want 0000", res_b); else n_pass++;
        @(negedge clk) arst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        n_total++; if (valid_a !== 1'b0 || ready_a !== 1'b1)
            $display("FAIL areset_discarded: got valid %b ready %b want 0 1", valid_a, ready_a);
        else n_pass++;
        run_op(1'b0, 32'h40800000, res, inv, cyc);
        n_total++; if (res !== 32'h40000000) $display("FAIL areset_rerun_result: got %h want 40000000", res); else n_pass++;
        n_total++; if (cyc != 27) $display("FAIL areset_rerun_latency: got %0d want 27", cyc); else n_pass++;
        do_ack(1'b0);
    endtask

    initial begin
        test_reset();
        test_normal();
        test_specials();
        test_half();
        test_hold();
        test_busy_start();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
